// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: NREAD combinational read lanes, two write ports, busy flag.
interface regfile_mp_if #(
   parameter int AWIDTH = 6,
   parameter int DWIDTH = 32,
   parameter int NREAD  = 2
);
   logic [NREAD*AWIDTH-1:0] ra;
   logic [NREAD*DWIDTH-1:0] rd;
   logic                    we0;
   logic [AWIDTH-1:0]       wa0;
   logic [DWIDTH-1:0]       wd0;
   logic                    we1;
   logic [AWIDTH-1:0]       wa1;
   logic [DWIDTH-1:0]       wd1;
   logic                    busy;

   modport master (output ra, we0, wa0, wd0, we1, wa1, wd1, input rd, busy);
   modport slave  (input ra, we0, wa0, wd0, we1, wa1, wd1, output rd, busy);
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep and optional zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read lanes.
module regfile_mp #(
   parameter int AWIDTH   = 6,
   parameter int DWIDTH   = 32,
   parameter int NREAD    = 2,
   parameter int ZERO_REG = 0
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  rf
);
   localparam int DEPTH = 2**AWIDTH;

   typedef enum logic {S_CLEAR, S_IDLE} state_e;

   state_e              state_q;
   logic [AWIDTH-1:0]   ptr_q;
   logic [DWIDTH-1:0]   mem_q [DEPTH];
   logic                busy;
   logic                wen0, wen1;
   logic [NREAD-1:0][DWIDTH-1:0] rd_lane;

   assign busy    = rst || (state_q == S_CLEAR);
   assign rf.busy = busy;

   // Writes to entry 0 are dropped when it is hardwired; gated off during the sweep.
   assign wen0 = rf.we0 && !busy && !((ZERO_REG != 0) && (rf.wa0 == '0));
   assign wen1 = rf.we1 && !busy && !((ZERO_REG != 0) && (rf.wa1 == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
      end else if (state_q == S_CLEAR) begin
         mem_q[ptr_q] <= '0;
         if (ptr_q == AWIDTH'(DEPTH-1)) state_q <= S_IDLE;
         else                           ptr_q   <= ptr_q + AWIDTH'(1);
      end else begin
         // Port 1 assigned last so it wins an address conflict.
         if (wen0) mem_q[rf.wa0] <= rf.wd0;
         if (wen1) mem_q[rf.wa1] <= rf.wd1;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AWIDTH-1:0] a;
      assign a = rf.ra[i*AWIDTH +: AWIDTH];
      always_comb begin
         rd_lane[i] = mem_q[a];
`ifdef REGFILE_BYPASS_EN
         if (wen0 && rf.wa0 == a) rd_lane[i] = rf.wd0;
         if (wen1 && rf.wa1 == a) rd_lane[i] = rf.wd1;
`endif
         if ((ZERO_REG != 0) && a == '0) rd_lane[i] = '0;
         if (busy)                       rd_lane[i] = '0;
      end
   end

   assign rf.rd = rd_lane;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two DUTs (ZERO_REG=0/1) on shared stimulus vs an array-based model.
module tb_regfile_mp;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   logic [AW-1:0] ra0, ra1, wa0, wa1;
   logic [DW-1:0] wd0, wd1;
   logic we0, we1;

   always #5 clk = ~clk;

   regfile_mp_if #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR)) rf0 ();
   regfile_mp_if #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR)) rf1 ();

   assign rf0.ra = {ra1, ra0};
   assign rf0.we0 = we0; assign rf0.wa0 = wa0; assign rf0.wd0 = wd0;
   assign rf0.we1 = we1; assign rf0.wa1 = wa1; assign rf0.wd1 = wd1;
   assign rf1.ra = {ra1, ra0};
   assign rf1.we0 = we0; assign rf1.wa0 = wa0; assign rf1.wd0 = wd0;
   assign rf1.we1 = we1; assign rf1.wa1 = wa1; assign rf1.wd1 = wd1;

   regfile_mp #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .ZERO_REG(0)) dut0 (.clk(clk), .rst(rst), .rf(rf0));
   regfile_mp #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .ZERO_REG(1)) dut1 (.clk(clk), .rst(rst), .rf(rf1));

   // Model: plain storage per DUT plus a count of sweep edges still owed.
   logic [DW-1:0] mdl [2][DEPTH];
   int sweep_left = DEPTH;
   int checks = 0;
   int errors = 0;

   function automatic bit m_busy();
      return rst || (sweep_left > 0);
   endfunction

   function automatic logic [DW-1:0] m_rd(int z, logic [AW-1:0] a);
      if (m_busy()) return '0;
      if (z == 1 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we1 && !(z == 1 && wa1 == 0) && wa1 == a) return wd1;
      if (we0 && !(z == 1 && wa0 == 0) && wa0 == a) return wd0;
`endif
      return mdl[z][a];
   endfunction

   task automatic model_edge();
      if (rst) sweep_left = DEPTH;
      else if (sweep_left > 0) begin
         for (int z = 0; z < 2; z++) mdl[z][DEPTH - sweep_left] = '0;
         sweep_left--;
      end else begin
         for (int z = 0; z < 2; z++) begin
            if (we0 && !(z == 1 && wa0 == 0)) mdl[z][wa0] = wd0;
            if (we1 && !(z == 1 && wa1 == 0)) mdl[z][wa1] = wd1;
         end
      end
   endtask

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("busy_z0", {31'd0, rf0.busy}, {31'd0, m_busy()});
      chk("busy_z1", {31'd0, rf1.busy}, {31'd0, m_busy()});
      chk("rd0_z0", rf0.rd[0*DW +: DW], m_rd(0, ra0));
      chk("rd1_z0", rf0.rd[1*DW +: DW], m_rd(0, ra1));
      chk("rd0_z1", rf1.rd[0*DW +: DW], m_rd(1, ra0));
      chk("rd1_z1", rf1.rd[1*DW +: DW], m_rd(1, ra1));
   endtask

   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
   endtask

   // Walks the sweep after rst is released; returns edges seen with busy high.
   task automatic count_sweep(output int n);
      n = 0;
      #1;
      while (rf0.busy && n < 200) begin
         step();
         n++;
         #1;
      end
   endtask

   typedef struct {
      logic we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
      logic we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
      logic [AW-1:0] rda;
      logic [DW-1:0] exp_z0;
      logic [DW-1:0] exp_z1;
   } vec_t;

   vec_t vt [7];

   initial begin
      int n;
      vt[0] = '{1, 6'd63, 32'hFFAAFFAA, 0, 6'd0,  32'h0,        6'd63, 32'hFFAAFFAA, 32'hFFAAFFAA};
      vt[1] = '{1, 6'd12, 32'h11111111, 1, 6'd12, 32'hAAAAAAAA, 6'd12, 32'hAAAAAAAA, 32'hAAAAAAAA};
      vt[2] = '{1, 6'd0,  32'hBBBBBBBB, 0, 6'd0,  32'h0,        6'd0,  32'hBBBBBBBB, 32'h0};
      vt[3] = '{0, 6'd0,  32'h0,        1, 6'd20, 32'h5A5A5A5A, 6'd20, 32'h5A5A5A5A, 32'h5A5A5A5A};
      vt[4] = '{1, 6'd30, 32'h01234567, 1, 6'd31, 32'h89ABCDEF, 6'd30, 32'h01234567, 32'h01234567};
      vt[5] = '{0, 6'd40, 32'hDEADBEEF, 0, 6'd41, 32'hFEEDFACE, 6'd40, 32'h0,        32'h0};
      vt[6] = '{0, 6'd0,  32'h0,        1, 6'd0,  32'hCCCCCCCC, 6'd0,  32'hCCCCCCCC, 32'h0};

      idle_inputs(); ra0 = '0; ra1 = '0;
      // Reset held two cycles; busy and rd forced regardless of prior state.
      rst = 1;
      step(); step();
      rst = 0;
      count_sweep(n);
      chk("sweep_len", n, 32'd64);
      for (int a = 0; a < DEPTH; a += 2) begin
         ra0 = AW'(a); ra1 = AW'(a + 1);
         #1;
         chk("clr_z0_l0", rf0.rd[0 +: DW], 32'h0);
         chk("clr_z0_l1", rf0.rd[DW +: DW], 32'h0);
         step();
      end

      // Directed vectors: write cycle (model-checked, incl. same-cycle read), then readback.
      for (int i = 0; i < 7; i++) begin
         we0 = vt[i].we0; wa0 = vt[i].wa0; wd0 = vt[i].wd0;
         we1 = vt[i].we1; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
         ra0 = vt[i].rda; ra1 = vt[i].rda;
         step();
         idle_inputs();
         #1;
         chk("vec_z0_l0", rf0.rd[0 +: DW], vt[i].exp_z0);
         chk("vec_z0_l1", rf0.rd[DW +: DW], vt[i].exp_z0);
         chk("vec_z1_l0", rf1.rd[0 +: DW], vt[i].exp_z1);
         chk("vec_z1_l1", rf1.rd[DW +: DW], vt[i].exp_z1);
         step();
      end

      // Bypass corner: read of the address being written by port 1 in the same cycle.
      we1 = 1; wa1 = 6'd7; wd1 = 32'hCAFEF00D; ra0 = 6'd7; ra1 = 6'd8;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_l0", rf0.rd[0 +: DW], 32'hCAFEF00D);
`else
      chk("nobypass_l0", rf0.rd[0 +: DW], 32'h0);
`endif
      step();
      idle_inputs();

      // Randomized traffic with rare resets.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         we0 = 1'($urandom); we1 = 1'($urandom);
         wa0 = AW'($urandom_range(0, 15)); wa1 = AW'($urandom_range(0, 15));
         wd0 = $urandom; wd1 = $urandom;
         ra0 = ($urandom_range(0, 1) == 1) ? wa1 : AW'($urandom_range(0, 15));
         ra1 = AW'($urandom_range(0, 15));
         step();
      end
      rst = 0; idle_inputs();
      count_sweep(n);

      // Mid-sweep reset with writes attempted throughout busy.
      we0 = 1; wa0 = 6'd5; wd0 = 32'h55555555;
      step();
      idle_inputs(); ra0 = 6'd5; ra1 = 6'd5;
      #1;
      chk("pre_a5", rf0.rd[0 +: DW], 32'h55555555);
      rst = 1; step();
      rst = 0; we0 = 1; wa0 = 6'd5; wd0 = 32'h12345678;
      for (int k = 0; k < 30; k++) step();
      rst = 1; step();
      rst = 0;
      count_sweep(n);
      chk("resweep_len", n, 32'd64);
      idle_inputs();
      #1;
      chk("a5_z0", rf0.rd[0 +: DW], 32'h0);
      chk("a5_z1", rf1.rd[DW +: DW], 32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
